uart_fifo_peripheral: RTL and testbench

Memory-mapped 8-bit UART with parametrised TX/RX FIFOs, a runtime-programmable baud divisor, sticky error flags and a level interrupt. It sits on the core's simple peripheral bus (enable / r_w / byte enable) and contains its own baud counters and TX/RX shift engines. Frame format is 8N1, or 8-bit with parity when the optional feature is compiled in.

---
 rtl/uart_fifo_peripheral.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_fifo_peripheral.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/uart_fifo_peripheral.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_fifo_peripheral: bus-mapped 8-bit UART with TX/RX FIFOs, baud       |
// | divisor, sticky error flags, level irq. Option macro: UART_PARITY_EN.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_fifo_peripheral #(
  parameter int CLK_HZ       = 50000000,
  parameter int BAUD_DEFAULT = 115200,
  parameter int TX_DEPTH     = 16,
  parameter int RX_DEPTH     = 16,
  parameter int DIV_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        r_w,
  input  logic [3:0]  byte_en,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        tx,
  input  logic        rx
);
  localparam int c_tx_aw = $clog2(TX_DEPTH);
  localparam int c_rx_aw = $clog2(RX_DEPTH);
  localparam logic [DIV_W-1:0] c_div_rst = DIV_W'(CLK_HZ / BAUD_DEFAULT);
  localparam logic [DIV_W-1:0] c_div_min = DIV_W'(8);
  localparam logic [DIV_W-1:0] c_div_one = DIV_W'(1);
  localparam logic [c_tx_aw:0] c_tx_one  = (c_tx_aw+1)'(1);
  localparam logic [c_rx_aw:0] c_rx_one  = (c_rx_aw+1)'(1);
`ifdef UART_PARITY_EN
  localparam logic [8:0] c_ctrl_mask = 9'h1F3;
`else
  localparam logic [8:0] c_ctrl_mask = 9'h073;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3, S_STOP = 3'd4
  } state_t;

  logic [8:0]       r_ctrl;
  logic [DIV_W-1:0] r_div, w_div_new;
  logic             r_tx_ovf, r_rx_ovr, r_frame_err, r_parity_err;
  logic [7:0]       r_tx_mem [TX_DEPTH];
  logic [7:0]       r_rx_mem [RX_DEPTH];
  logic [c_tx_aw:0] r_tx_wp, r_tx_rp;
  logic [c_rx_aw:0] r_rx_wp, r_rx_rp, w_rx_count;
  logic [31:0]      w_rx_cnt32, w_status;
  logic [3:0]       w_rx_cnt_sat;
  state_t           r_tx_state, r_rx_state;
  logic [DIV_W-1:0] r_tx_cnt, r_tx_div, r_rx_cnt, r_rx_div;
  logic [2:0]       r_tx_bit, r_rx_bit;
  logic [7:0]       r_tx_sh, r_rx_sh, r_rx_byte;
  logic             r_tx_par, r_tx_pen, r_rx_pen, r_rx_podd, r_rx_pbad;
  logic             r_rx_s1, r_rx_s2, r_rx_s3, r_rx_push, r_ferr_set, r_perr_set;
  logic             w_par_en, w_par_odd, w_unused;

`ifdef UART_PARITY_EN
  assign w_par_en  = r_ctrl[8];
  assign w_par_odd = r_ctrl[7];
`else
  assign w_par_en  = 1'b0;
  assign w_par_odd = 1'b0;
`endif
  assign w_unused = ^{wdata, byte_en};

  wire w_wr        = enable & ~r_w;
  wire w_rd        = enable & r_w;
  wire w_ctrl_wr   = w_wr & (addr == 2'd2);
  wire w_st_clr    = w_wr & (addr == 2'd1);
  wire w_tx_flush  = w_ctrl_wr & byte_en[0] & wdata[2];
  wire w_rx_flush  = w_ctrl_wr & byte_en[0] & wdata[3];
  wire w_tx_empty  = (r_tx_wp == r_tx_rp);
  wire w_tx_full   = (r_tx_wp[c_tx_aw] != r_tx_rp[c_tx_aw]) &&
                     (r_tx_wp[c_tx_aw-1:0] == r_tx_rp[c_tx_aw-1:0]);
  wire w_rx_empty  = (r_rx_wp == r_rx_rp);
  wire w_rx_full   = (r_rx_wp[c_rx_aw] != r_rx_rp[c_rx_aw]) &&
                     (r_rx_wp[c_rx_aw-1:0] == r_rx_rp[c_rx_aw-1:0]);
  wire w_tx_busy   = (r_tx_state != S_IDLE);
  wire w_tx_req    = w_wr & (addr == 2'd0) & byte_en[0];
  wire w_tx_push   = w_tx_req & ~w_tx_full;
  wire w_tx_pop    = (r_tx_state == S_IDLE) & r_ctrl[0] & ~w_tx_empty;
  wire w_rx_pop    = w_rd & (addr == 2'd0) & ~w_rx_empty;
  wire w_rx_push   = r_rx_push & ~w_rx_full;
  wire [7:0] w_tx_head = r_tx_mem[r_tx_rp[c_tx_aw-1:0]];
  wire [7:0] w_rx_head = r_rx_mem[r_rx_rp[c_rx_aw-1:0]];

  assign w_rx_count   = r_rx_wp - r_rx_rp;
  assign w_rx_cnt32   = 32'(w_rx_count);
  assign w_rx_cnt_sat = (w_rx_cnt32 > 32'd15) ? 4'hF : w_rx_cnt32[3:0];
  assign w_status = {16'd0, w_rx_cnt_sat, 3'd0, r_parity_err, r_frame_err, r_rx_ovr,
                     r_tx_ovf, w_tx_busy, w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};

  always_comb begin
    w_div_new = r_div;
    for (int i = 0; i < DIV_W; i++)
      if (byte_en[i/8]) w_div_new[i] = wdata[i];
  end

  // Control, divisor, sticky flags, read data and interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl <= '0; r_div <= c_div_rst; rdata <= '0; irq <= 1'b0;
      r_tx_ovf <= 1'b0; r_rx_ovr <= 1'b0; r_frame_err <= 1'b0; r_parity_err <= 1'b0;
    end else begin
      if (w_ctrl_wr && byte_en[0]) r_ctrl[7:0] <= wdata[7:0] & c_ctrl_mask[7:0];
      if (w_ctrl_wr && byte_en[1]) r_ctrl[8] <= wdata[8] & c_ctrl_mask[8];
      if (w_wr && addr == 2'd3) r_div <= (w_div_new < c_div_min) ? c_div_min : w_div_new;
      // A new error in the same cycle as its clear wins.
      r_tx_ovf     <= (r_tx_ovf & ~(w_st_clr & byte_en[0] & wdata[5])) | (w_tx_req & w_tx_full);
      r_rx_ovr     <= (r_rx_ovr & ~(w_st_clr & byte_en[0] & wdata[6])) | (r_rx_push & w_rx_full);
      r_frame_err  <= (r_frame_err & ~(w_st_clr & byte_en[0] & wdata[7])) | r_ferr_set;
      r_parity_err <= (r_parity_err & ~(w_st_clr & byte_en[1] & wdata[8])) | r_perr_set;
      if (w_rd) begin
        case (addr)
          2'd0:    rdata <= w_rx_empty ? 32'd0 : {23'd0, 1'b1, w_rx_head};
          2'd1:    rdata <= w_status;
          2'd2:    rdata <= {23'd0, r_ctrl};
          default: rdata <= 32'(r_div);
        endcase
      end
      irq <= (r_ctrl[4] & ~w_rx_empty) | (r_ctrl[5] & w_tx_empty & ~w_tx_busy) |
             (r_ctrl[6] & (r_tx_ovf | r_rx_ovr | r_frame_err | r_parity_err));
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[c_tx_aw-1:0]] <= wdata[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wp[c_rx_aw-1:0]] <= r_rx_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_wp <= '0; r_tx_rp <= '0; r_rx_wp <= '0; r_rx_rp <= '0;
    end else begin
      if (w_tx_flush) begin
        r_tx_wp <= '0; r_tx_rp <= '0;
      end else begin
        if (w_tx_push) r_tx_wp <= r_tx_wp + c_tx_one;
        if (w_tx_pop)  r_tx_rp <= r_tx_rp + c_tx_one;
      end
      if (w_rx_flush) begin
        r_rx_wp <= '0; r_rx_rp <= '0;
      end else begin
        if (w_rx_push) r_rx_wp <= r_rx_wp + c_rx_one;
        if (w_rx_pop)  r_rx_rp <= r_rx_rp + c_rx_one;
      end
    end
  end

  // Transmitter: divisor and parity mode are captured at frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= S_IDLE; tx <= 1'b1; r_tx_cnt <= '0; r_tx_div <= c_div_min;
      r_tx_bit <= '0; r_tx_sh <= '0; r_tx_par <= 1'b0; r_tx_pen <= 1'b0;
    end else if (r_tx_state == S_IDLE) begin
      if (w_tx_pop) begin
        r_tx_state <= S_START; tx <= 1'b0; r_tx_cnt <= '0; r_tx_div <= r_div;
        r_tx_bit <= '0; r_tx_sh <= w_tx_head;
        r_tx_par <= (^w_tx_head) ^ w_par_odd; r_tx_pen <= w_par_en;
      end
    end else if (r_tx_cnt == r_tx_div - c_div_one) begin
      r_tx_cnt <= '0;
      case (r_tx_state)
        S_START: begin r_tx_state <= S_DATA; tx <= r_tx_sh[0]; end
        S_DATA: begin
          if (r_tx_bit == 3'd7) begin
            r_tx_state <= r_tx_pen ? S_PARITY : S_STOP;
            tx <= r_tx_pen ? r_tx_par : 1'b1;
          end else begin
            r_tx_bit <= r_tx_bit + 3'd1; r_tx_sh <= r_tx_sh >> 1; tx <= r_tx_sh[1];
          end
        end
        S_PARITY: begin r_tx_state <= S_STOP; tx <= 1'b1; end
        default:  begin r_tx_state <= S_IDLE; tx <= 1'b1; end
      endcase
    end else begin
      r_tx_cnt <= r_tx_cnt + c_div_one;
    end
  end

  wire w_rx_fall = r_rx_s3 & ~r_rx_s2;
  wire w_rx_half = (r_rx_cnt == (r_rx_div >> 1));
  wire w_rx_end  = (r_rx_cnt == r_rx_div - c_div_one);

  // Receiver: returns to IDLE at mid-stop so back-to-back frames are caught.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_s1 <= 1'b1; r_rx_s2 <= 1'b1; r_rx_s3 <= 1'b1;
      r_rx_state <= S_IDLE; r_rx_cnt <= '0; r_rx_div <= c_div_min; r_rx_bit <= '0;
      r_rx_sh <= '0; r_rx_byte <= '0; r_rx_pen <= 1'b0; r_rx_podd <= 1'b0; r_rx_pbad <= 1'b0;
      r_rx_push <= 1'b0; r_ferr_set <= 1'b0; r_perr_set <= 1'b0;
    end else begin
      r_rx_s1 <= rx; r_rx_s2 <= r_rx_s1; r_rx_s3 <= r_rx_s2;
      r_rx_push <= 1'b0; r_ferr_set <= 1'b0; r_perr_set <= 1'b0;
      if (r_rx_state != S_IDLE && !r_ctrl[1]) begin
        r_rx_state <= S_IDLE;
      end else if (r_rx_state == S_IDLE) begin
        if (r_ctrl[1] && w_rx_fall) begin
          r_rx_state <= S_START; r_rx_cnt <= '0; r_rx_div <= r_div; r_rx_bit <= '0;
          r_rx_pen <= w_par_en; r_rx_podd <= w_par_odd; r_rx_pbad <= 1'b0;
        end
      end else begin
        r_rx_cnt <= w_rx_end ? '0 : r_rx_cnt + c_div_one;
        case (r_rx_state)
          S_START: begin
            if (w_rx_half && r_rx_s2) r_rx_state <= S_IDLE;
            else if (w_rx_end)        r_rx_state <= S_DATA;
          end
          S_DATA: begin
            if (w_rx_half) r_rx_sh <= {r_rx_s2, r_rx_sh[7:1]};
            if (w_rx_end) begin
              if (r_rx_bit == 3'd7) r_rx_state <= r_rx_pen ? S_PARITY : S_STOP;
              else                  r_rx_bit <= r_rx_bit + 3'd1;
            end
          end
          S_PARITY: begin
            if (w_rx_half) r_rx_pbad <= r_rx_s2 ^ (^r_rx_sh) ^ r_rx_podd;
            if (w_rx_end)  r_rx_state <= S_STOP;
          end
          default: begin
            if (w_rx_half) begin
              r_rx_state <= S_IDLE;
              if (!r_rx_s2) begin
                r_ferr_set <= 1'b1;
              end else begin
                r_rx_push <= 1'b1; r_rx_byte <= r_rx_sh; r_perr_set <= r_rx_pen & r_rx_pbad;
              end
            end
          end
        endcase
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_peripheral.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_fifo_peripheral: directed self-checking bench for the UART.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_uart_fifo_peripheral;
  logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, r_w = 1'b0;
  logic [3:0]  byte_en = '0;
  logic [1:0]  addr = '0;
  logic [31:0] wdata = '0, rdata, d;
  logic        irq, tx, rx_drv = 1'b1, loop = 1'b0;
  logic        rx;
  int          total = 0, bad = 0;

  assign rx = loop ? tx : rx_drv;

  uart_fifo_peripheral dut (
    .clk(clk), .rst(rst), .enable(enable), .r_w(r_w), .byte_en(byte_en),
    .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq), .tx(tx), .rx(rx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] v);
    @(negedge clk); enable = 1'b1; r_w = 1'b0; addr = a; byte_en = be; wdata = v;
    @(negedge clk); enable = 1'b0; byte_en = '0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] v);
    @(negedge clk); enable = 1'b1; r_w = 1'b1; addr = a;
    @(negedge clk); enable = 1'b0; r_w = 1'b0; v = rdata;
  endtask

  // Drives one frame on rx at 8 clocks per bit, then idles high.
  task automatic send_rx(input logic [7:0] v, input bit use_par, input bit par, input bit stop);
    logic [10:0] seq;
    int n;
    if (use_par) begin seq = {stop, par, v, 1'b0}; n = 11; end
    else         begin seq = {1'b0, stop, v, 1'b0}; n = 10; end
    for (int i = 0; i < n; i++) begin
      rx_drv = seq[i];
      repeat (8) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] frame_byte;
    int n;
    logic exp_bit;
    repeat (3) @(negedge clk);
    check("rst_rdata", rdata, 32'd0);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;

    bus_rd(2'd3, d); check("div_reset", d, 32'd434);
    bus_rd(2'd1, d); check("status_reset", d, 32'h0000000A);
    bus_wr(2'd3, 4'b0011, 32'd3); bus_rd(2'd3, d); check("div_clamp", d, 32'd8);
    bus_wr(2'd3, 4'b0011, 32'd8);

    bus_wr(2'd2, 4'b0011, 32'h1FF); bus_rd(2'd2, d);
`ifdef UART_PARITY_EN
    check("ctrl_readback", d, 32'h1F3);
`else
    check("ctrl_readback", d, 32'h073);
`endif
    check("irq_tx_empty", {31'd0, irq}, 32'd1);
    bus_wr(2'd2, 4'b0011, 32'h0);

    // Single TX frame of 0xA5, every clock position checked.
    bus_wr(2'd2, 4'b0011, 32'h01);
    bus_wr(2'd0, 4'b0001, 32'hA5);
    n = 0;
    while (tx !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    check("tx_start_seen", {31'd0, n < 20}, 32'd1);
    frame_byte = 8'hA5;
    for (int p = 0; p <= 80; p++) begin
      if (p < 8)       exp_bit = 1'b0;
      else if (p < 72) exp_bit = frame_byte[(p - 8) / 8];
      else             exp_bit = 1'b1;
      check($sformatf("tx_bit_p%0d", p), {31'd0, tx}, {31'd0, exp_bit});
      @(negedge clk);
    end
    bus_rd(2'd1, d); check("status_tx_done", d, 32'h0000000A);

    // Loopback of two bytes.
    loop = 1'b1;
    bus_wr(2'd2, 4'b0011, 32'h03);
    bus_wr(2'd0, 4'b0001, 32'h3C);
    bus_wr(2'd0, 4'b0001, 32'hC3);
    repeat (220) @(negedge clk);
    bus_rd(2'd1, d); check("status_rx2", d, 32'h00002002);
    bus_rd(2'd0, d); check("rx_data0", d, 32'h13C);
    bus_rd(2'd0, d); check("rx_data1", d, 32'h1C3);
    bus_rd(2'd0, d); check("rx_empty_read", d, 32'h000);
    loop = 1'b0;

    // TX overflow, W1C, flush.
    bus_wr(2'd2, 4'b0011, 32'h00);
    for (int i = 0; i < 17; i++) bus_wr(2'd0, 4'b0001, 32'(i));
    bus_rd(2'd1, d); check("status_tx_ovf", d, 32'h00000029);
    bus_wr(2'd1, 4'b0001, 32'h20);
    bus_rd(2'd1, d); check("status_ovf_clr", d, 32'h00000009);
    bus_wr(2'd2, 4'b0011, 32'h04);
    bus_rd(2'd1, d); check("status_flushed", d, 32'h0000000A);
    bus_rd(2'd2, d); check("ctrl_flush_rb", d, 32'h0);

    // Framing error with error interrupt.
    bus_wr(2'd2, 4'b0011, 32'h42);
    send_rx(8'h55, 1'b0, 1'b0, 1'b0);
    bus_rd(2'd1, d); check("status_frame_err", d, 32'h0000008A);
    check("irq_err", {31'd0, irq}, 32'd1);
    bus_rd(2'd0, d); check("ferr_no_data", d, 32'h0);
    bus_wr(2'd1, 4'b0001, 32'h80);
    repeat (3) @(negedge clk);
    check("irq_err_clr", {31'd0, irq}, 32'd0);
    bus_rd(2'd1, d); check("status_ferr_clr", d, 32'h0000000A);

`ifdef UART_PARITY_EN
    // Even parity: 0x07 needs parity 1, send 0.
    bus_wr(2'd2, 4'b0011, 32'h102);
    send_rx(8'h07, 1'b1, 1'b0, 1'b1);
    bus_rd(2'd1, d); check("status_parity_err", d, 32'h00001102);
    bus_rd(2'd0, d); check("parity_data", d, 32'h107);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
